// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, PC-source and fetch-state definitions for the 16-bit CPU
package cpu_pkg;

    // Opcodes occupy instr[15:12].
    localparam logic [3:0] OP_JAL  = 4'h0;
    localparam logic [3:0] OP_JALR = 4'h1;
    localparam logic [3:0] OP_BEQ  = 4'h2;
    localparam logic [3:0] OP_BNE  = 4'h3;
    localparam logic [3:0] OP_LW   = 4'h4;
    localparam logic [3:0] OP_SW   = 4'h5;
    localparam logic [3:0] OP_ADD  = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_SLT  = 4'hB;
    localparam logic [3:0] OP_ADDI = 4'hC;
    localparam logic [3:0] OP_LUI  = 4'hD;
    localparam logic [3:0] OP_ANDI = 4'hE;
    localparam logic [3:0] OP_ORI  = 4'hF;

    // Next-PC source selection from the control unit; encoding 3 is reserved
    // and behaves as sequential.
    localparam logic [1:0] PCSRC_SEQ = 2'd0;
    localparam logic [1:0] PCSRC_REL = 2'd1;
    localparam logic [1:0] PCSRC_REG = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - combinational next-PC selection (PC+2, PC+imm, rs1+imm)
//
// Ports:
//   pc       in   current program counter
//   imm      in   sign-extended offset / immediate
//   rs1_val  in   register base for jalr
//   pcsrc    in   source select (cpu_pkg PCSRC_*; 3 treated as sequential)
//   next_pc  out  selected target, modulo 2^ADDR_W, alignment not applied
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] imm,
    input  logic [ADDR_W-1:0] rs1_val,
    input  logic [1:0]        pcsrc,
    output logic [ADDR_W-1:0] next_pc
);

    always_comb begin
        next_pc = pc + ADDR_W'(2);
        case (pcsrc)
            PCSRC_REL: next_pc = pc + imm;
            PCSRC_REG: next_pc = rs1_val + imm;
            default:   next_pc = pc + ADDR_W'(2);
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: owns PC and IR, req/ack instruction memory handshake
//
// Build option: define IFU_MISALIGN_TRAP_EN to add the sticky misalign_err
// output; otherwise odd targets are silently aligned.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   imem_req/imem_addr    fetch request and byte address (= pc)
//   imem_ack/imem_rdata   memory response, data valid with ack
//   instr/op/instr_valid  IR, its opcode field, IR-not-yet-accepted flag
//   instr_ready           execute accepts IR; pcsrc/imm/rs1_val valid with it
//   pc/pc_plus2           address of IR and its link value
//   misalign_err          (optional) sticky odd-target flag
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         op,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic [1:0]         pcsrc,
    input  logic [ADDR_W-1:0]  imm,
    input  logic [ADDR_W-1:0]  rs1_val,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus2
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    output logic               misalign_err
`endif
);

    // Clears bit 0 of a target address; instructions are halfword aligned.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~{{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [ADDR_W-1:0]   next_pc;
    logic [ADDR_W-1:0]   next_pc_aligned;

    pc_next_mux #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_mux (
        .pc      (pc_q),
        .imm     (imm),
        .rs1_val (rs1_val),
        .pcsrc   (pcsrc),
        .next_pc (next_pc)
    );

    assign next_pc_aligned = next_pc & ALIGN_MASK;

`ifdef IFU_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
`ifdef IFU_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    pc_d    = next_pc_aligned;
                    state_d = REQ;
`ifdef IFU_MISALIGN_TRAP_EN
                    if (next_pc[0]) begin
                        misalign_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
`ifdef IFU_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
`ifdef IFU_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Request and valid are pure state decodes, so both are low out of reset
    // and drop on the same edge that leaves REQ / HOLD.
    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr       = ir_q;
    assign op          = ir_q[INSTR_W-1 -: 4];
    assign instr_valid = (state_q == HOLD);
    assign pc          = pc_q;
    assign pc_plus2    = pc_q + ADDR_W'(2);
`ifdef IFU_MISALIGN_TRAP_EN
    assign misalign_err = misalign_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [3:0]  op;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  pcsrc;
    logic [15:0] imm;
    logic [15:0] rs1_val;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
`ifdef IFU_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [15:0] m_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W   (16),
        .INSTR_W  (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .op          (op),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pcsrc       (pcsrc),
        .imm         (imm),
        .rs1_val     (rs1_val),
        .pc          (pc),
        .pc_plus2    (pc_plus2)
`ifdef IFU_MISALIGN_TRAP_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    // Reference: target chosen by pcsrc, wrapped at 64 KiB, forced even.
    function automatic logic [15:0] model_next(input logic [15:0] cur, input logic [1:0] src,
                                               input logic [15:0] im, input logic [15:0] base);
        int unsigned t;
        if (src == 2'd1)      t = int'(cur) + int'(im);
        else if (src == 2'd2) t = int'(base) + int'(im);
        else                  t = int'(cur) + 2;
        t = t % 65536;
        t = (t / 2) * 2;
        return 16'(t);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory returns data after the given number of wait cycles (caller is in REQ).
    task automatic fetch(input logic [15:0] data, input int waits);
        imem_ack = 1'b0;
        repeat (waits) tick();
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic accept(input logic [1:0] src, input logic [15:0] im, input logic [15:0] base);
        pcsrc = src; imm = im; rs1_val = base;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        m_pc = model_next(m_pc, src, im, base);
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        pcsrc = '0; imm = '0; rs1_val = '0;
        tick(); tick();
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", pc); end
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h want 0000", instr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        rst = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL idle_to_req: got %b want 1", imem_req); end
        m_pc = 16'h0000;
    endtask

    task automatic test_first_fetch();
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL first_addr: got %h want 0000", imem_addr); end
        fetch(16'h8123, 0);
        checks++; if (instr !== 16'h8123) begin errors++; $display("FAIL first_instr: got %h want 8123", instr); end
        checks++; if (op !== 4'h8) begin errors++; $display("FAIL first_op: got %h want 8", op); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req: got %b want 0", imem_req); end
    endtask

    task automatic test_sequential();
        accept(2'd0, 16'h0000, 16'h0000);
        checks++; if (imem_addr !== 16'h0002) begin errors++; $display("FAIL seq_addr: got %h want 0002", imem_addr); end
        checks++; if (pc_plus2 !== 16'h0004) begin errors++; $display("FAIL seq_pc_plus2: got %h want 0004", pc_plus2); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_valid: got %b want 0", instr_valid); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req: got %b want 1", imem_req); end
    endtask

    task automatic test_branches();
        fetch(16'h1000, 0); accept(2'd1, 16'h000E, 16'h0000);
        checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL rel_setup: got %h want 0010", pc); end
        fetch(16'h2000, 1); accept(2'd1, 16'hFFF8, 16'h0000);
        checks++; if (pc !== 16'h0008) begin errors++; $display("FAIL rel_neg: got %h want 0008", pc); end
        fetch(16'h3000, 0); accept(2'd2, 16'h0006, 16'h0100);
        checks++; if (pc !== 16'h0106) begin errors++; $display("FAIL reg_jump: got %h want 0106", pc); end
        fetch(16'h4000, 0); accept(2'd3, 16'h1234, 16'h4444);
        checks++; if (pc !== 16'h0108) begin errors++; $display("FAIL reserved_src: got %h want 0108", pc); end
    endtask

    task automatic test_wrap_and_align();
        fetch(16'h5000, 0); accept(2'd2, 16'h0000, 16'hFFFE);
        checks++; if (pc !== 16'hFFFE) begin errors++; $display("FAIL wrap_setup: got %h want fffe", pc); end
        checks++; if (pc_plus2 !== 16'h0000) begin errors++; $display("FAIL wrap_pc_plus2: got %h want 0000", pc_plus2); end
        fetch(16'h6000, 0); accept(2'd0, 16'h0000, 16'h0000);
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc: got %h want 0000", pc); end
        fetch(16'h7000, 0); accept(2'd2, 16'h0000, 16'h0101);
        checks++; if (pc !== 16'h0100) begin errors++; $display("FAIL odd_target: got %h want 0100", pc); end
`ifdef IFU_MISALIGN_TRAP_EN
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_set: got %b want 1", misalign_err); end
`endif
    endtask

    task automatic test_stall();
        logic [15:0] addr0;
        addr0 = imem_addr;
        for (int i = 0; i < 5; i++) begin
            instr_ready = (i == 2);
            pcsrc = 2'd1; imm = 16'h0040;
            tick();
            checks++; if (imem_req !== 1'b1 || imem_addr !== addr0 || pc !== m_pc) begin
                errors++; $display("FAIL stall_%0d: req=%b addr=%h pc=%h want req=1 addr=%h", i, imem_req, imem_addr, pc, m_pc);
            end
        end
        instr_ready = 1'b0;
        fetch(16'h9ABC, 0);
        checks++; if (instr !== 16'h9ABC || instr_valid !== 1'b1) begin errors++; $display("FAIL stall_done: instr=%h valid=%b want 9abc 1", instr, instr_valid); end
        imem_ack = 1'b1; imem_rdata = 16'hFFFF;
        tick();
        imem_ack = 1'b0;
        checks++; if (instr !== 16'h9ABC) begin errors++; $display("FAIL hold_ack_ignored: got %h want 9abc", instr); end
        accept(2'd0, 16'h0000, 16'h0000);
    endtask

    task automatic test_reset_collisions();
        imem_ack = 1'b1; imem_rdata = 16'h5ABC; rst = 1'b1;
        tick();
        imem_ack = 1'b0; rst = 1'b0;
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL rst_ack_instr: got %h want 0000", instr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_ack_valid: got %b want 0", instr_valid); end
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL rst_ack_pc: got %h want 0000", pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_ack_req: got %b want 0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL refetch: req=%b addr=%h want 1 0000", imem_req, imem_addr); end
        m_pc = 16'h0000;
        fetch(16'h7777, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (instr !== 16'h0000 || instr_valid !== 1'b0) begin errors++; $display("FAIL rst_hold: instr=%h valid=%b want 0000 0", instr, instr_valid); end
`ifdef IFU_MISALIGN_TRAP_EN
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL misalign_clear: got %b want 0", misalign_err); end
`endif
        tick();
        m_pc = 16'h0000;
    endtask

    task automatic test_random();
        logic [15:0] data;
        logic [1:0]  src;
        int          hold;
        for (int n = 0; n < 40; n++) begin
            data = 16'($urandom);
            checks++; if (imem_req !== 1'b1 || imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr_%0d: req=%b addr=%h want 1 %h", n, imem_req, imem_addr, m_pc); end
            fetch(data, $urandom_range(0, 3));
            checks++; if (instr !== data || op !== data[15:12] || pc_plus2 !== 16'(m_pc + 16'd2)) begin
                errors++; $display("FAIL rnd_fetch_%0d: instr=%h op=%h pc_plus2=%h want %h %h %h", n, instr, op, pc_plus2, data, data[15:12], 16'(m_pc + 16'd2));
            end
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                imem_ack = 1'($urandom); imem_rdata = 16'($urandom);
                tick();
            end
            imem_ack = 1'b0;
            checks++; if (instr !== data || instr_valid !== 1'b1) begin errors++; $display("FAIL rnd_hold_%0d: instr=%h valid=%b want %h 1", n, instr, instr_valid, data); end
            src = 2'($urandom);
            accept(src, 16'($urandom), 16'($urandom));
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc_%0d: got %h want %h", n, pc, m_pc); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_sequential();
        test_branches();
        test_wrap_and_align();
        test_stall();
        test_reset_collisions();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the 16-bit CPU; it owns the program counter (PC) and the instruction register (IR).
- Issues requests to instruction memory with a req/ack handshake and captures the 16-bit instruction.
- Presents the opcode to the control unit and holds it until execute accepts it.
- On acceptance, loads the next PC using the control unit's PCsrc selection: PC+2, PC+imm, or rs1+imm.

Parameters:
- ADDR_W, 16, PC and instruction-memory byte-address width.
- INSTR_W, 16, instruction width. op is always the top 4 bits.
- RESET_PC, 16'h0000, PC value loaded by reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  byte address of the fetch; equals pc.
- imem_ack  in  1  memory has returned data this cycle.
- imem_rdata  in  INSTR_W  instruction data; valid when imem_ack=1.
- instr  out  INSTR_W  IR contents.
- op  out  4  instr[15:12], routed to the control unit op input.
- instr_valid  out  1  IR holds an instruction not yet accepted.
- instr_ready  in  1  execute accepts the instruction. pcsrc, imm and rs1_val must be valid in the same cycle.
- pcsrc  in  2  0: PC+2, 1: PC+imm, 2: rs1_val+imm, 3: reserved (treated as 0).
- imm  in  ADDR_W  sign-extended byte offset or immediate.
- rs1_val  in  ADDR_W  jalr base register value.
- pc  out  ADDR_W  address of the instruction in IR.
- pc_plus2  out  ADDR_W  pc+2; the link value written by jal/jalr.

Behaviour:
- Clocking and reset:
  - One clock domain: clk. Reset rst is synchronous and active-high.
- Reset values:
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, state=IDLE.
- State machine (states IDLE, REQ, HOLD):
  - IDLE: lasts one cycle after rst deasserts, then moves to REQ.
  - REQ: imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - REQ, on an edge where imem_ack=1: IR<=imem_rdata, instr_valid<=1, imem_req<=0, go to HOLD.
  - HOLD: IR and pc held; instr_valid=1.
  - HOLD, on an edge where instr_ready=1: pc<=next_pc, instr_valid<=0, go to REQ.
- Latency and throughput:
  - A zero-wait-state memory (ack in the first REQ cycle) gives 2 cycles per instruction minimum.
  - instr_valid rises on the edge after ack.
- next_pc arithmetic:
  - Modulo 2^ADDR_W, so 16'hFFFE+2 wraps to 16'h0000.
  - imm is already sign-extended; it is added as two's complement.
- Ignored inputs:
  - imem_ack outside REQ is ignored.
  - instr_ready outside HOLD is ignored; pc is not updated.
- Simultaneous events:
  - rst has priority over everything in the same cycle. Any in-flight ack is discarded and imem_req drops on that edge.
  - Reset in HOLD discards the IR contents.
- Reserved encoding: pcsrc=3 behaves exactly as pcsrc=0.
- Derived outputs: pc_plus2 is combinational from pc. op is combinational from IR.

Optional Feature:
- Macro: IFU_MISALIGN_TRAP_EN.
- Defined:
  - Extra output port misalign_err (1 bit).
  - If next_pc[0]=1 at the accept edge, misalign_err<=1, pc<=next_pc with bit0 cleared, and the FSM goes to REQ.
  - misalign_err is sticky until rst.
- Undefined:
  - No misalign_err port.
  - next_pc[0] is silently forced to 0.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants OP_JAL=4'h0 through OP_ORI=4'hF;
  - PCsrc encodings PCSRC_SEQ=0, PCSRC_REL=1, PCSRC_REG=2;
  - the fetch state enum {IDLE, REQ, HOLD}.
- One combinational sub-module, pc_next_mux: inputs pc, imm, rs1_val, pcsrc; output next_pc. It is reusable by a later branch-predict stage.

Test Plan:
- Reset, then memory acks in the first REQ cycle with 16'h8123:
  - imem_addr=0000 in the first REQ cycle.
  - instr=8123, op=8 and instr_valid=1 on the next cycle.
- HOLD with instr_ready=1, pcsrc=0, pc=0000: next imem_addr=0002 and pc_plus2=0004.
- pc=0010 with pcsrc=1, imm=16'hFFF8 (-8): next pc=0008. Then pcsrc=2, rs1_val=0100, imm=0006: next pc=0106.
- pc=FFFE with pcsrc=0: pc wraps to 0000.
- Memory stalls 5 cycles:
  - imem_req stays 1 and imem_addr stays stable throughout.
  - instr_ready pulsed during REQ is ignored and pc is unchanged.
- rst asserted in the same cycle as imem_ack with data 16'h5ABC:
  - instr stays 0 and instr_valid=0.
  - pc returns to RESET_PC.
  - Refetch begins 2 cycles after rst deasserts.
  - With IFU_MISALIGN_TRAP_EN defined, rs1_val=0101, imm=0 and pcsrc=2 give misalign_err=1 and pc=0100.
